// File: rtl/display_7seg_pkg.sv
// Shared constants for the 7-segment capture path: active-low {g..a} glyphs,
// field widths and the capture FSM state encoding.
package display_7seg_pkg;

    localparam int DIGIT_W = 8;
    localparam int CODE_W  = 4;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_A    = 7'h08;
    localparam logic [6:0] SEG_B    = 7'h03;
    localparam logic [6:0] SEG_C    = 7'h46;
    localparam logic [6:0] SEG_D    = 7'h21;
    localparam logic [6:0] SEG_E    = 7'h06;
    localparam logic [6:0] SEG_F    = 7'h0E;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_DECODE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/seg2num_capture_seg2hex.sv
// Combinational glyph decoder: one active-low 7-segment pattern to its hex code,
// flagging the dash glyph and any unrecognised pattern (blank included).
module seg2hex
    import display_7seg_pkg::*;
(
    input  logic [6:0]        i_seg,
    output logic [CODE_W-1:0] o_code,
    output logic              o_dash,
    output logic              o_invalid
);

    // Pattern lookup; dash and unknown patterns decode to code 0.
    always_comb begin
        o_code    = 4'h0;
        o_dash    = 1'b0;
        o_invalid = 1'b0;
        case (i_seg)
            SEG_0:    o_code = 4'h0;
            SEG_1:    o_code = 4'h1;
            SEG_2:    o_code = 4'h2;
            SEG_3:    o_code = 4'h3;
            SEG_4:    o_code = 4'h4;
            SEG_5:    o_code = 4'h5;
            SEG_6:    o_code = 4'h6;
            SEG_7:    o_code = 4'h7;
            SEG_8:    o_code = 4'h8;
            SEG_9:    o_code = 4'h9;
            SEG_A:    o_code = 4'hA;
            SEG_B:    o_code = 4'hB;
            SEG_C:    o_code = 4'hC;
            SEG_D:    o_code = 4'hD;
            SEG_E:    o_code = 4'hE;
            SEG_F:    o_code = 4'hF;
            SEG_DASH: o_dash = 1'b1;
            default:  o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg2num_capture.sv
// Captures an active-low segment bus, waits for it to settle, decodes each digit and
// folds the digits MSD-first into a binary value. SEG2NUM_SIGN_EN adds o_neg (MSD dash = minus).
module seg2num_capture
    import display_7seg_pkg::*;
#(
    parameter int N_DIGITS      = 2,
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 10,
    parameter int BIN_W         = 7
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic [DIGIT_W*N_DIGITS-1:0]  i_SEG,
    output logic [CODE_W*N_DIGITS-1:0]   o_hex,
    output logic [N_DIGITS-1:0]          o_dp,
    output logic [BIN_W-1:0]             o_num,
    output logic                         o_err,
    output logic                         o_valid,
`ifdef SEG2NUM_SIGN_EN
    output logic                         o_busy,
    output logic                         o_neg
`else
    output logic                         o_busy
`endif
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SEG_W = DIGIT_W * N_DIGITS;

    logic [SEG_W-1:0]                seg_q, prev_q;
    logic                            pending_q, pending_d;
    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [BIN_W-1:0]                acc_q, acc_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [N_DIGITS-1:0][CODE_W-1:0] code_q, dec_code_s;
    logic [N_DIGITS-1:0]             dp_q, dec_dp_s, dec_dash_s, dec_inv_s;
    logic                            frame_err_q, frame_err_s;
    logic                            changed_s, latch_s, emit_s;
    logic [CODE_W*N_DIGITS-1:0]      hex_q;
    logic [N_DIGITS-1:0]             dp_out_q;
    logic [BIN_W-1:0]                num_q;
    logic                            err_q, valid_q, busy_q;
`ifdef SEG2NUM_SIGN_EN
    logic                            neg_s, neg_q, neg_out_q;
`endif

    assign changed_s = (seg_q != prev_q);

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        seg2hex u_seg2hex (
            .i_seg     (seg_q[DIGIT_W*k +: 7]),
            .o_code    (dec_code_s[k]),
            .o_dash    (dec_dash_s[k]),
            .o_invalid (dec_inv_s[k])
        );
        assign dec_dp_s[k] = ~seg_q[DIGIT_W*k + 7];
    end

    // Frame-level error (and sign) from the per-digit decodes.
    always_comb begin
        frame_err_s = 1'b0;
`ifdef SEG2NUM_SIGN_EN
        neg_s = 1'b0;
`endif
        for (int k = 0; k < N_DIGITS; k++) begin
            frame_err_s = frame_err_s | dec_inv_s[k] | (dec_code_s[k] > 4'd9);
`ifdef SEG2NUM_SIGN_EN
            if (k == N_DIGITS - 1) begin
                neg_s = dec_dash_s[k];
            end else begin
                frame_err_s = frame_err_s | dec_dash_s[k];
            end
`else
            frame_err_s = frame_err_s | dec_dash_s[k];
`endif
        end
    end

    // Next-state logic; any bus change before the result is emitted restarts settling.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        latch_s   = 1'b0;
        emit_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (changed_s || pending_q) begin
                    state_d   = ST_SETTLE;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (changed_s) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = ST_DECODE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (changed_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    latch_s = 1'b1;
                    acc_d   = '0;
                    idx_d   = IDX_W'(N_DIGITS - 1);
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (changed_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    // acc*10 + digit, MSD first
                    acc_d = {acc_q[BIN_W-4:0], 3'b000} + {acc_q[BIN_W-2:0], 1'b0}
                          + {{(BIN_W-CODE_W){1'b0}}, code_q[idx_q]};
                    if (idx_q == IDX_W'(0)) begin
                        emit_s  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                if (changed_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Input sampling, FSM state, settle counter, accumulator and decoded-frame latch.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            seg_q       <= '0;
            prev_q      <= '0;
            pending_q   <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            code_q      <= '0;
            dp_q        <= '0;
            frame_err_q <= 1'b0;
`ifdef SEG2NUM_SIGN_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            seg_q     <= i_SEG;
            prev_q    <= seg_q;
            pending_q <= pending_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            if (latch_s) begin
                code_q      <= dec_code_s;
                dp_q        <= dec_dp_s;
                frame_err_q <= frame_err_s;
`ifdef SEG2NUM_SIGN_EN
                neg_q       <= neg_s;
`endif
            end
        end
    end

    // Result registers: loaded together with the o_valid strobe, held otherwise.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            hex_q    <= '0;
            dp_out_q <= '0;
            num_q    <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SEG2NUM_SIGN_EN
            neg_out_q <= 1'b0;
`endif
        end else begin
            valid_q <= emit_s;
            busy_q  <= (state_d != ST_IDLE);
            if (emit_s) begin
                hex_q    <= code_q;
                dp_out_q <= dp_q;
                err_q    <= frame_err_q;
                num_q    <= frame_err_q ? '0 : acc_d;
`ifdef SEG2NUM_SIGN_EN
                neg_out_q <= neg_q & ~frame_err_q;
`endif
            end
        end
    end

    assign o_hex   = hex_q;
    assign o_dp    = dp_out_q;
    assign o_num   = num_q;
    assign o_err   = err_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
`ifdef SEG2NUM_SIGN_EN
    assign o_neg   = neg_out_q;
`endif

endmodule
